bcd_write_sequencer: RTL and testbench
======================================

BCD_WRITE_SEQUENCER -- requirements
Module: bcd_write_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 8'h21: write address of the seconds field; the other fields use the following consecutive addresses.
REQ-002 Parameter ACK_TIMEOUT, default 8'd255: maximum number of cycles to wait for wr_ack in either handshake phase.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request to convert and write one time snapshot; sampled only in IDLE.
REQ-006 Ports sec, min, hour, day, month, year, input, 8 each: binary time fields.
REQ-007 Port conv_in, output, 8: binary operand driven to the shared combinational binary-to-BCD converter.
REQ-008 Port conv_out, input, 8: BCD result returned by the converter in the same cycle.
REQ-009 Ports wr_req (output, 1), wr_addr (output, 8), wr_data (output, 8), wr_ack (input, 1): four-phase register-write handshake.
REQ-010 Port busy, output, 1: high from the cycle after start is accepted until the block returns to IDLE.
REQ-011 Port done, output, 1: one-cycle pulse after all six fields are written.
REQ-012 Port range_err, output, 6: one bit per field, bit0 = sec through bit5 = year; sticky until the next accepted start.
REQ-013 Port timeout_err, output, 1: sticky until the next accepted start.

Function
REQ-014 States SHALL be IDLE, CONV, REQ, RELEASE and DONE.
REQ-015 IDLE, with start=1: snapshot all six fields, clear range_err and timeout_err, set idx=0, go to CONV; busy goes high the next cycle.
REQ-016 start SHALL be ignored outside IDLE; input changes after the snapshot SHALL have no effect.
REQ-017 Valid ranges SHALL be:
 - sec and min: 0..59
 - hour: 0..23
 - day: 1..31
 - month: 1..12
 - year: 0..59 (the converter's valid range is 0..59)
REQ-018 CONV (one cycle): drive conv_in with snapshot[idx] if in range, else with 8'h00 and set range_err[idx]; register conv_out into wr_data and BASE_ADDR+idx into wr_addr; go to REQ.
REQ-019 conv_in SHALL be 8'h00 in every state except CONV.
REQ-020 REQ: assert wr_req with wr_addr and wr_data stable; when wr_ack=1, deassert wr_req next cycle and go to RELEASE.
REQ-021 RELEASE: wait for wr_ack=0, then do one of:
 - if idx<5: idx+1, go to CONV;
 - if idx=5: go to DONE.
REQ-022 DONE (one cycle): done=1, busy=0 next cycle, go to IDLE.
REQ-023 Each field SHALL take at least 3 cycles (CONV + REQ + RELEASE).
REQ-024 Timeout counter: clears on entry to REQ and to RELEASE; increments each cycle in either state.
REQ-025 On timeout (counter reaches ACK_TIMEOUT): set timeout_err, drop wr_req, go to IDLE; done SHALL NOT pulse and the remaining fields SHALL NOT be written.
REQ-026 wr_ack seen high in CONV or IDLE SHALL be ignored.
REQ-027 Out-of-range fields SHALL still be written (as 8'h00), so every complete sequence performs exactly 6 writes.

Reset
REQ-028 When rst_n=0, asynchronously and while it is held:
 - state = IDLE, idx = 0, counter = 0;
 - wr_req, wr_addr, wr_data, conv_in, busy, done, range_err, timeout_err all 0.
REQ-029 Reset mid-handshake SHALL drop wr_req within the same cycle, and no write SHALL be issued after reset release until a new start.

Verification
REQ-030 Scenario: sec=45, min=7, hour=23, day=31, month=12, year=24, responder acks one cycle after req -> writes are {21:45, 22:07, 23:23, 24:31, 25:12, 26:24} in order; one done pulse; range_err=0.
REQ-031 Scenario: month=13, day=0, other fields valid -> the 0x25 and 0x24 writes carry 8'h00; range_err=6'b010_000 | 6'b001_000 = 6'b011000; done pulses.
REQ-032 Scenario: wr_ack never asserts -> wr_req drops after 255 cycles; timeout_err=1; busy=0; done stays 0; no write to 0x22.
REQ-033 Scenario: start pulsed again during the third write, and sec changed mid-sequence -> the sequence is unaffected; exactly 6 writes; a second start after done writes the new values.
REQ-034 Scenario: rst_n low while in REQ for 0x23 -> wr_req=0 immediately; all outputs 0; no further writes until the next start.
REQ-035 Scenario: wr_ack held high for 3 cycles after req drops -> the block stays in RELEASE, and the next CONV starts only after ack falls.

Source files
------------

// File: rtl/bcd_write_sequencer.sv
// Converts a six-field binary time snapshot to BCD through a shared converter
// and writes each field to consecutive register addresses over a req/ack handshake.
`timescale 1ns/1ps
module bcd_write_sequencer #(
    parameter logic [7:0] BASE_ADDR   = 8'h21,
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic [7:0] day,
    input  logic [7:0] month,
    input  logic [7:0] year,
    output logic [7:0] conv_in,
    input  logic [7:0] conv_out,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    output logic       busy,
    output logic       done,
    output logic [5:0] range_err,
    output logic       timeout_err
);

    localparam int unsigned NFIELDS = 6;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DW      = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFIELDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_REQ,
        S_RELEASE,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [NFIELDS-1:0][DW-1:0]    snap_q, snap_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [DW-1:0]                 cnt_q, cnt_d;
    logic [DW-1:0]                 conv_in_q, conv_in_d;
    logic                          wr_req_q, wr_req_d;
    logic [DW-1:0]                 wr_addr_q, wr_addr_d;
    logic [DW-1:0]                 wr_data_q, wr_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [NFIELDS-1:0]            range_err_q, range_err_d;
    logic                          timeout_err_q, timeout_err_d;

    logic [NFIELDS-1:0][DW-1:0]    fields_in;
    logic [IDX_W-1:0]              idx_nxt;
    logic                          cnt_expired;

    // Per-field legal range; the converter itself only handles 0..59.
    function automatic logic field_ok(input logic [IDX_W-1:0] i, input logic [DW-1:0] v);
        case (i)
            3'd0, 3'd1, 3'd5: field_ok = (v <= 8'd59);
            3'd2:             field_ok = (v <= 8'd23);
            3'd3:             field_ok = (v >= 8'd1) && (v <= 8'd31);
            3'd4:             field_ok = (v >= 8'd1) && (v <= 8'd12);
            default:          field_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] operand(input logic [IDX_W-1:0] i, input logic [DW-1:0] v);
        operand = field_ok(i, v) ? v : 8'h00;
    endfunction

    assign fields_in   = {year, month, day, hour, min, sec};
    assign idx_nxt     = idx_q + IDX_W'(1);
    assign cnt_expired = ((9'(cnt_q) + 9'd1) >= 9'(ACK_TIMEOUT));

    // Next-state and registered-output logic; conv_in is loaded on entry to CONV.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        conv_in_d     = '0;
        wr_req_d      = wr_req_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        range_err_d   = range_err_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d        = fields_in;
                    range_err_d   = '0;
                    timeout_err_d = 1'b0;
                    idx_d         = '0;
                    busy_d        = 1'b1;
                    conv_in_d     = operand(IDX_W'(0), sec);
                    state_d       = S_CONV;
                end
            end
            S_CONV: begin
                if (!field_ok(idx_q, snap_q[idx_q])) begin
                    range_err_d[idx_q] = 1'b1;
                end
                wr_data_d = conv_out;
                wr_addr_d = BASE_ADDR + DW'(idx_q);
                wr_req_d  = 1'b1;
                cnt_d     = '0;
                state_d   = S_REQ;
            end
            S_REQ: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RELEASE;
                end else if (cnt_expired) begin
                    wr_req_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    idx_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_RELEASE: begin
                if (!wr_ack) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_nxt;
                        conv_in_d = operand(idx_nxt, snap_q[idx_nxt]);
                        state_d   = S_CONV;
                    end
                end else if (cnt_expired) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    idx_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                wr_req_d = 1'b0;
                busy_d   = 1'b0;
                idx_d    = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            snap_q        <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            conv_in_q     <= '0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            range_err_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            conv_in_q     <= conv_in_d;
            wr_req_q      <= wr_req_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            range_err_q   <= range_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign conv_in     = conv_in_q;
    assign wr_req      = wr_req_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign range_err   = range_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bcd_write_sequencer.sv
// Bench for bcd_write_sequencer: converter and ack responder models, a write
// scoreboard built from the field ranges, and directed scenarios.
`timescale 1ns/1ps
module tb_bcd_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] f [6];
    logic [7:0] sec, min, hour, day, month, year;
    logic [7:0] conv_in, conv_out;
    logic       wr_req, wr_ack;
    logic [7:0] wr_addr, wr_data;
    logic       busy, done, timeout_err;
    logic [5:0] range_err;

    always #5 clk = ~clk;

    assign sec   = f[0];
    assign min   = f[1];
    assign hour  = f[2];
    assign day   = f[3];
    assign month = f[4];
    assign year  = f[5];

    bcd_write_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .conv_in(conv_in), .conv_out(conv_out),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done), .range_err(range_err), .timeout_err(timeout_err)
    );

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [7:0] t;
        t[7:4] = 4'(v / 10);
        t[3:0] = 4'(v % 10);
        return t;
    endfunction

    assign conv_out = to_bcd(conv_in);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_q [$];
    wr_t        obs [$];
    logic [5:0] exp_mask = '0;

    function automatic bit in_range(input int i, input int v);
        case (i)
            0, 1, 5: return v <= 59;
            2:       return v <= 23;
            3:       return v >= 1 && v <= 31;
            4:       return v >= 1 && v <= 12;
            default: return 0;
        endcase
    endfunction

    task automatic load_expect();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            wr_t e;
            e.a = 8'(8'h21 + i);
            e.d = in_range(i, int'(f[i])) ? to_bcd(f[i]) : 8'h00;
            exp_q.push_back(e);
            exp_mask[i] = !in_range(i, int'(f[i]));
        end
    endtask

    // Responder: 0 = ack follows req by one cycle, 1 = never ack, 2 = hold ack 3 extra cycles
    int ack_mode = 0;
    int hold;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack <= 1'b0;
            hold   <= 0;
        end else begin
            case (ack_mode)
                1: wr_ack <= 1'b0;
                2: begin
                    if (wr_req) begin
                        wr_ack <= 1'b1;
                        hold   <= 3;
                    end else if (hold > 0) begin
                        wr_ack <= 1'b1;
                        hold   <= hold - 1;
                    end else begin
                        wr_ack <= 1'b0;
                    end
                end
                default: wr_ack <= wr_req;
            endcase
        end
    end

    // Per-cycle compare against the scoreboard
    logic prev_req = 1'b0;
    int   ack_low = 0, req_len = 0, last_req_len = 0, n_wr = 0, n_done = 0;
    wr_t  cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
            ack_low  = 0;
            req_len  = 0;
        end else begin
            if (wr_req && !prev_req) begin
                wr_t o;
                o.a = wr_addr;
                o.d = wr_data;
                n_wr++;
                obs.push_back(o);
                req_len = 0;
                chk("req_after_ack_low", 32'(ack_low >= 2), 1);
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", wr_addr, cur.a);
                    chk("wr_data", wr_data, cur.d);
                end else begin
                    cur = o;
                end
            end
            if (wr_req) begin
                req_len++;
                chk("addr_stable", wr_addr, cur.a);
                chk("data_stable", wr_data, cur.d);
            end else if (prev_req) begin
                last_req_len = req_len;
            end
            if (wr_req || !busy) chk("conv_in_zero", conv_in, 0);
            if (done) begin
                n_done++;
                chk("done_all_written", exp_q.size(), 0);
                chk("done_range_err", range_err, exp_mask);
                chk("done_busy", busy, 1);
            end
            ack_low  = wr_ack ? 0 : ack_low + 1;
            prev_req = wr_req;
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_addr(input string nm, input logic [7:0] a, input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (wr_req && wr_addr == a) seen = 1;
        end
        chk({nm, "_addr_seen"}, 32'(seen), 1);
    endtask

    task automatic set_fields(input int s, input int mi, input int h, input int d, input int mo, input int y);
        f[0] = 8'(s); f[1] = 8'(mi); f[2] = 8'(h);
        f[3] = 8'(d); f[4] = 8'(mo); f[5] = 8'(y);
    endtask

    int w0, d0;
    logic [7:0] lit_a [6];
    logic [7:0] lit_d [6];

    initial begin
        set_fields(0, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_conv_in", conv_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal snapshot
        set_fields(45, 7, 23, 31, 12, 24);
        load_expect();
        w0 = n_wr; d0 = n_done;
        do_start();
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        wait_done("nominal", 200);
        chk("nominal_writes", n_wr - w0, 6);
        chk("nominal_done_pulses", n_done - d0, 1);
        chk("nominal_range_err", range_err, 6'b000000);
        chk("nominal_timeout_err", timeout_err, 0);
        chk("nominal_busy_end", busy, 0);
        lit_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        lit_d = '{8'h45, 8'h07, 8'h23, 8'h31, 8'h12, 8'h24};
        for (int i = 0; i < 6; i++) begin
            chk("nominal_lit_addr", obs[w0 + i].a, lit_a[i]);
            chk("nominal_lit_data", obs[w0 + i].d, lit_d[i]);
        end

        // Out-of-range day and month
        set_fields(45, 7, 23, 0, 13, 24);
        load_expect();
        w0 = n_wr; d0 = n_done;
        do_start();
        wait_done("range", 200);
        chk("range_writes", n_wr - w0, 6);
        chk("range_done_pulses", n_done - d0, 1);
        chk("range_err_lit", range_err, 6'b011000);
        chk("range_day_data_lit", obs[w0 + 3].d, 8'h00);
        chk("range_month_data_lit", obs[w0 + 4].d, 8'h00);

        // Ack held after req drops; range boundaries
        ack_mode = 2;
        set_fields(59, 59, 0, 1, 1, 0);
        load_expect();
        w0 = n_wr; d0 = n_done;
        do_start();
        wait_done("hold", 300);
        chk("hold_writes", n_wr - w0, 6);
        chk("hold_range_err", range_err, 0);
        chk("hold_sec_data_lit", obs[w0].d, 8'h59);
        ack_mode = 0;
        repeat (6) @(negedge clk);

        // Restart and input change mid-sequence are ignored
        set_fields(10, 20, 5, 15, 6, 30);
        load_expect();
        w0 = n_wr; d0 = n_done;
        do_start();
        wait_addr("restart", 8'h23, 100);
        f[0] = 8'd33; f[5] = 8'd40;
        do_start();
        wait_done("restart", 200);
        chk("restart_writes", n_wr - w0, 6);
        chk("restart_done_pulses", n_done - d0, 1);
        chk("restart_old_sec_lit", obs[w0].d, 8'h10);
        load_expect();
        w0 = n_wr;
        do_start();
        wait_done("second", 200);
        chk("second_writes", n_wr - w0, 6);
        chk("second_sec_lit", obs[w0].d, 8'h33);
        chk("second_year_lit", obs[w0 + 5].d, 8'h40);

        // Ack never arrives
        ack_mode = 1;
        set_fields(45, 7, 23, 31, 12, 24);
        load_expect();
        w0 = n_wr; d0 = n_done;
        do_start();
        begin
            bit fell = 0;
            for (int i = 0; i < 600 && !fell; i++) begin
                @(negedge clk);
                if (!busy) fell = 1;
            end
            chk("timeout_busy_fell", 32'(fell), 1);
        end
        repeat (3) @(negedge clk);
        chk("timeout_err", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_wr_req", wr_req, 0);
        chk("timeout_no_done", n_done - d0, 0);
        chk("timeout_one_write", n_wr - w0, 1);
        chk("timeout_req_len", last_req_len, 255);
        exp_q.delete();
        ack_mode = 0;

        // Reset during the 0x23 handshake
        set_fields(12, 34, 11, 9, 3, 15);
        load_expect();
        do_start();
        wait_addr("reset", 8'h23, 100);
        chk("restart_clears_timeout", timeout_err, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_range_err", range_err, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = n_wr;
        repeat (30) @(negedge clk);
        chk("post_rst_no_writes", n_wr - w0, 0);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
